// File: rtl/cpu_pkg.sv
// Shared datapath constants for the 16-bit MIPS-style CPU.
package cpu_pkg;

  // Address and datapath width in bits.
  localparam int ADDR_W = 16;

  // Boot vector that the PC takes on reset.
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

endpackage : cpu_pkg

// File: rtl/en_reg.sv
// Generic load-enabled register with synchronous active-high reset.
// Intended for the PC and the IF/ID pipeline registers.
//   rst_i has priority over en_i.
//   With en_i low, q_o holds its value.
//   d_i is loaded verbatim, with no masking and no arithmetic.
//   An X on en_i while rst_i is low gives X on the bits where d_i and q_o differ,
//   so an undriven stall line is visible in simulation instead of looking like a hold.
module en_reg #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state select: reset vector, new value, or hold.
  always_comb begin
    q_d = q_q;
    if (rst_i) begin
      q_d = RESET_VALUE;
    end else begin
      q_d = en_i ? d_i : q_q;
    end
  end

  // State register; every change happens on the rising edge only.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  // Drive the output straight from the flop so no input reaches it combinationally.
  assign q_o = q_q;

endmodule : en_reg

// File: rtl/pc.sv
// Program counter: holds the current fetch address for instruction memory.
// It loads pc_plus on a rising edge when pc_write is high.
// The hazard logic drives pc_write low to freeze fetch.
// rst is synchronous and forces the boot vector.
module pc
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VECTOR[WIDTH-1:0]
) (
  input  logic [WIDTH-1:0] pc_plus,
  input  logic             clk,
  input  logic             pc_write,
  input  logic             rst,
  output logic [WIDTH-1:0] address
);

  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pc_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (pc_write),
    .d_i   (pc_plus),
    .q_o   (address)
  );

`ifdef PC_ASSERT
  logic             rst_seen_q;
  logic             prev_rst_q;
  logic             prev_hold_q;
  logic [WIDTH-1:0] prev_addr_q;

  // Record what happened at the previous edge so this edge's result can be checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_seen_q <= 1'b1;
    end
    prev_rst_q  <= rst;
    prev_hold_q <= !rst && !pc_write;
    prev_addr_q <= address;
  end

  // Check reset result, stall hold, and clean control inputs once out of power-up.
  always @(posedge clk) begin
    if (rst_seen_q) begin
      assert (!$isunknown(rst))
        else $error("pc: rst is X");
      assert (rst || !$isunknown(pc_write))
        else $error("pc: pc_write is X");
      assert (!(prev_rst_q === 1'b1) || (address == RESET_VALUE))
        else $error("pc: address not RESET_VALUE after reset edge");
      assert (!(prev_hold_q === 1'b1) || (address == prev_addr_q))
        else $error("pc: address changed while stalled");
    end
  end
`endif

endmodule : pc

// File: tb/tb_pc.sv
// Directed and randomised bench for the program-counter register.
module tb_pc;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         pc_write;
  logic [W-1:0] pc_plus;
  logic [W-1:0] address;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_pc;
  int           tests_run;
  int           tests_failed;

  pc dut (
    .pc_plus  (pc_plus),
    .clk      (clk),
    .pc_write (pc_write),
    .rst      (rst),
    .address  (address)
  );

  // Clock: 20 time-unit period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive the control and data inputs.
  task automatic drive(input logic r, input logic w, input logic [W-1:0] p);
    rst      = r;
    pc_write = w;
    pc_plus  = p;
  endtask

  // Pop the oldest expected address and compare it with the DUT output.
  task automatic check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: scoreboard empty, address=%h", tag, address);
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      assert (address === e)
        else begin
          tests_failed++;
          $error("FAIL %s: address=%h expected=%h", tag, address, e);
        end
    end
  endtask

  // Queue the expectation, take one rising edge, and sample 1 unit after it.
  task automatic edge_check(input logic [W-1:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Independent reference: what the PC must hold after one edge with these inputs.
  function automatic logic [W-1:0] next_pc(input logic r, input logic w,
                                           input logic [W-1:0] p, input logic [W-1:0] cur);
    if (r) return 16'h0000;
    if (w) return p;
    return cur;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // 1. Reset while pc_plus carries a value that must be ignored.
    drive(1'b1, 1'b0, 16'hFF67);
    edge_check(16'h0000, "reset");
    edge_check(16'h0000, "reset_hold");

    // 2. Load, then change pc_plus mid-cycle.
    drive(1'b0, 1'b1, 16'hFF67);
    edge_check(16'hFF67, "load");
    pc_plus = 16'h0011;
    #4;
    exp_q.push_back(16'hFF67);
    check("load_mid_cycle");
    edge_check(16'h0011, "load_next");

    // 3. Stall for several edges.
    drive(1'b0, 1'b0, 16'h670C);
    for (int i = 0; i < 4; i++) begin
      edge_check(16'h0011, "stall");
    end

    // 4. Reset has priority over pc_write.
    drive(1'b1, 1'b1, 16'h670C);
    edge_check(16'h0000, "reset_priority");
    rst = 1'b0;
    edge_check(16'h670C, "load_after_reset");

    // 5. A reset pulse that falls between edges must not change address.
    drive(1'b0, 1'b0, 16'h1234);
    #4;
    rst = 1'b1;
    #3;
    exp_q.push_back(16'h670C);
    check("sync_mid_pulse");
    #4;
    rst = 1'b0;
    edge_check(16'h670C, "sync_after_pulse");

    // 6. Boundary values are loaded verbatim.
    drive(1'b0, 1'b1, 16'hFFFF);
    edge_check(16'hFFFF, "boundary_ffff");
    pc_plus = 16'h0000;
    edge_check(16'h0000, "boundary_0000");
    pc_plus = 16'h8001;
    edge_check(16'h8001, "boundary_8001");

    // Random mix of load, stall and occasional reset against the reference.
    model_pc = 16'h8001;
    for (int i = 0; i < 24; i++) begin
      logic         r;
      logic         w;
      logic [W-1:0] p;
      r = ($urandom_range(0, 7) == 0);
      w = 1'($urandom_range(0, 1));
      p = W'($urandom_range(0, 16'hFFFF));
      drive(r, w, p);
      model_pc = next_pc(r, w, p, model_pc);
      edge_check(model_pc, "random");
    end

    if (exp_q.size() != 0) begin
      tests_failed++;
      $error("FAIL leftover: %0d expectations never checked", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc
